// File: rtl/tap_delay_line.sv
// Sample delay line for the Hilbert filter taps: DEPTH stages of WIDTH bits,
// with per-stage valid flags, a saturating fill count and a registered tap mux.
module tap_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int SEL_W = 3
) (
    input  logic                   clk,
    input  logic                   RST_n,
    input  logic                   EN,
    input  logic                   CLR,
    input  logic [WIDTH-1:0]       D,
    input  logic                   D_valid,
    output logic [WIDTH*DEPTH-1:0] TAPS,
    output logic [DEPTH-1:0]       TAP_VALID,
    input  logic [SEL_W-1:0]       TAP_SEL,
    output logic [WIDTH-1:0]       TAP_OUT,
    output logic [WIDTH-1:0]       Q,
    output logic                   Q_valid,
    output logic [SEL_W:0]         FILL,
    output logic                   FULL,
    output logic                   SHIFTED
);

    localparam logic [SEL_W:0] FILL_MAX = (SEL_W+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] stg;
    logic [DEPTH-1:0]            vld;
    logic [SEL_W:0]              fill;
    logic                        full;
    logic                        shifted;
    logic [WIDTH-1:0]            tap_out;
    logic [WIDTH-1:0]            sel_tap;
    logic                        shift;

    assign shift = EN & D_valid & ~CLR;

    // Out-of-range selects (possible when DEPTH is not a power of two) read 0.
    always_comb begin
        sel_tap = '0;
        for (int k = 0; k < DEPTH; k++)
            if (TAP_SEL == SEL_W'(k)) sel_tap = stg[k];
    end

    always_ff @(posedge clk) begin
        if (!RST_n || CLR) begin
            stg     <= '0;
            vld     <= '0;
            fill    <= '0;
            full    <= 1'b0;
            shifted <= 1'b0;
            tap_out <= '0;
        end else begin
            tap_out <= sel_tap;
            shifted <= shift;
            if (shift) begin
                stg <= {stg[DEPTH-2:0], D};
                vld <= {vld[DEPTH-2:0], 1'b1};
                if (fill != FILL_MAX) fill <= fill + 1'b1;
                full <= (fill >= FILL_MAX - 1'b1);
            end
        end
    end

    assign TAPS      = stg;
    assign TAP_VALID = vld;
    assign TAP_OUT   = tap_out;
    assign Q         = stg[DEPTH-1];
    assign Q_valid   = vld[DEPTH-1];
    assign FILL      = fill;
    assign FULL      = full;
    assign SHIFTED   = shifted;

endmodule

// File: tb/tb_tap_delay_line.sv
// Bench for tap_delay_line: a 4-deep and a 6-deep line driven in lockstep and
// checked against a queue model (newest sample at the front).
module tb_tap_delay_line;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, clr, dv;
    logic [7:0] d;
    logic [1:0] sel_a;
    logic [2:0] sel_b;

    logic [31:0] taps_a;
    logic [3:0]  tv_a;
    logic [7:0]  to_a, q_a;
    logic        qv_a, full_a, sh_a;
    logic [2:0]  fill_a;

    logic [47:0] taps_b;
    logic [5:0]  tv_b;
    logic [7:0]  to_b, q_b;
    logic        qv_b, full_b, sh_b;
    logic [3:0]  fill_b;

    tap_delay_line #(.WIDTH(8), .DEPTH(4), .SEL_W(2)) dut_a (
        .clk(clk), .RST_n(rst_n), .EN(en), .CLR(clr), .D(d), .D_valid(dv),
        .TAPS(taps_a), .TAP_VALID(tv_a), .TAP_SEL(sel_a), .TAP_OUT(to_a),
        .Q(q_a), .Q_valid(qv_a), .FILL(fill_a), .FULL(full_a), .SHIFTED(sh_a));

    tap_delay_line #(.WIDTH(8), .DEPTH(6), .SEL_W(3)) dut_b (
        .clk(clk), .RST_n(rst_n), .EN(en), .CLR(clr), .D(d), .D_valid(dv),
        .TAPS(taps_b), .TAP_VALID(tv_b), .TAP_SEL(sel_b), .TAP_OUT(to_b),
        .Q(q_b), .Q_valid(qv_b), .FILL(fill_b), .FULL(full_b), .SHIFTED(sh_b));

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] e_to_a, e_to_b;
    logic       e_sh;

    function automatic logic [7:0] tap_a(input int k);
        return (k < qa.size()) ? qa[k] : 8'h00;
    endfunction

    function automatic logic [7:0] tap_b(input int k);
        return (k < 6 && k < qb.size()) ? qb[k] : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [63:0] ta, tb;
        ta = '0;
        tb = '0;
        for (int k = 0; k < 4; k++) ta[k*8 +: 8] = tap_a(k);
        for (int k = 0; k < 6; k++) tb[k*8 +: 8] = tap_b(k);
        check("taps_a",    64'(taps_a), ta);
        check("tvalid_a",  64'(tv_a),   64'((1 << qa.size()) - 1));
        check("fill_a",    64'(fill_a), 64'(qa.size()));
        check("full_a",    64'(full_a), 64'(qa.size() == 4));
        check("shifted_a", 64'(sh_a),   64'(e_sh));
        check("tapout_a",  64'(to_a),   64'(e_to_a));
        check("q_a",       64'(q_a),    64'(tap_a(3)));
        check("qvalid_a",  64'(qv_a),   64'(qa.size() == 4));
        check("taps_b",    64'(taps_b), tb);
        check("tvalid_b",  64'(tv_b),   64'((1 << qb.size()) - 1));
        check("fill_b",    64'(fill_b), 64'(qb.size()));
        check("full_b",    64'(full_b), 64'(qb.size() == 6));
        check("shifted_b", 64'(sh_b),   64'(e_sh));
        check("tapout_b",  64'(to_b),   64'(e_to_b));
        check("q_b",       64'(q_b),    64'(tap_b(5)));
    endtask

    // One clock: drive at negedge, advance the model, check 1 ns after posedge.
    task automatic step(input logic r, input logic e, input logic c, input logic [7:0] dd,
                        input logic v, input logic [1:0] sa, input logic [2:0] sb);
        @(negedge clk);
        rst_n = r; en = e; clr = c; d = dd; dv = v; sel_a = sa; sel_b = sb;
        if (!r || c) begin
            qa.delete();
            qb.delete();
            e_to_a = 8'h00;
            e_to_b = 8'h00;
            e_sh   = 1'b0;
        end else begin
            e_to_a = tap_a(int'(sa));
            e_to_b = tap_b(int'(sb));
            e_sh   = e && v;
            if (e && v) begin
                qa.push_front(dd);
                qb.push_front(dd);
                if (qa.size() > 4) void'(qa.pop_back());
                if (qb.size() > 6) void'(qb.pop_back());
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; d = 8'h00; dv = 1'b0;
        sel_a = 2'd0; sel_b = 3'd0;
        e_to_a = 8'h00; e_to_b = 8'h00; e_sh = 1'b0;

        // reset held while pushing
        step(0, 1, 0, 8'hFF, 1, 0, 0);
        step(0, 1, 0, 8'hFF, 1, 0, 0);

        // fill and saturate
        step(1, 1, 0, 8'h11, 1, 0, 0);
        step(1, 1, 0, 8'h22, 1, 0, 0);
        step(1, 1, 0, 8'h33, 1, 0, 0);
        step(1, 1, 0, 8'h44, 1, 0, 0);
        step(1, 1, 0, 8'h55, 1, 0, 0);
        check("q_after_fill", 64'(q_a), 64'h22);
        check("full_after_fill", 64'(full_a), 64'h1);

        // tap readout, including an out-of-range select on the 6-deep line
        step(1, 1, 0, 8'h00, 0, 2, 7);
        check("tapout_sel2", 64'(to_a), 64'h33);
        check("tapout_sel7", 64'(to_b), 64'h00);
        step(1, 1, 0, 8'h00, 0, 0, 4);
        check("tapout_sel0", 64'(to_a), 64'h55);
        check("tapout_b_sel4", 64'(to_b), 64'h11);

        // flush wins over a same-cycle push
        step(1, 1, 1, 8'h99, 1, 1, 1);
        step(1, 1, 0, 8'h99, 1, 0, 0);
        check("stage0_after_flush", 64'(taps_a[7:0]), 64'h99);
        check("tvalid_after_flush", 64'(tv_a), 64'h1);

        // gaps and disabled pushes
        step(1, 1, 1, 8'h00, 0, 0, 0);
        step(1, 1, 0, 8'hA1, 1, 0, 0);
        step(1, 1, 0, 8'h00, 0, 0, 0);
        step(1, 1, 0, 8'h00, 0, 0, 0);
        step(1, 1, 0, 8'h00, 0, 0, 0);
        step(1, 0, 0, 8'hB2, 1, 0, 0);
        check("stage0_hold", 64'(taps_a[7:0]), 64'hA1);
        check("fill_hold", 64'(fill_a), 64'h1);

        // reset mid-fill with CLR and push also asserted
        step(1, 1, 0, 8'h01, 1, 0, 0);
        step(1, 1, 0, 8'h02, 1, 0, 0);
        step(0, 1, 1, 8'h77, 1, 0, 0);
        step(1, 1, 0, 8'h10, 1, 0, 0);
        step(1, 1, 0, 8'h20, 1, 0, 0);
        step(1, 1, 0, 8'h30, 1, 0, 0);
        step(1, 1, 0, 8'h40, 1, 3, 5);
        check("full_after_refill", 64'(full_a), 64'h1);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0, 8'($urandom), $urandom_range(0, 2) != 0,
                 2'($urandom), 3'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tap_delay_line.md
Name: tap_delay_line

Overview:
Parametrised multi-stage register chain that generalises the single-stage enable/reset flip-flop register to DEPTH stages of WIDTH bits. It is the sample delay line feeding the Hilbert filter taps. Every stage is exposed in parallel, one stage can be selected for registered readout, and per-stage valid flags plus a fill counter let downstream MAC logic ignore taps still holding reset data. A synchronous flush clears the line between data blocks without a global reset.

Parameters:
WIDTH, 16, bits per sample/stage
DEPTH, 8, number of stages (>= 2)
SEL_W, 3, width of TAP_SEL and of FILL minus one; must equal ceil(log2(DEPTH)), fixed by instantiator

Ports:
clk  in  1  clock, all logic on rising edge
RST_n  in  1  synchronous active-low reset
EN  in  1  global enable; no state change when 0 (except reset/CLR)
CLR  in  1  synchronous flush
D  in  WIDTH  input sample
D_valid  in  1  D carries a new sample this cycle
TAPS  out  WIDTH*DEPTH  stage k at bits [k*WIDTH +: WIDTH]; stage 0 newest
TAP_VALID  out  DEPTH  bit k = stage k holds a real sample
TAP_SEL  in  SEL_W  stage index for TAP_OUT
TAP_OUT  out  WIDTH  registered copy of selected stage
Q  out  WIDTH  last stage (stage DEPTH-1), combinational alias of TAPS top slice
Q_valid  out  1  TAP_VALID[DEPTH-1]
FILL  out  SEL_W+1  valid sample count, saturates at DEPTH
FULL  out  1  FILL == DEPTH, registered
SHIFTED  out  1  one-cycle pulse, high the cycle after a shift occurred

Behaviour:
- Reset (RST_n=0 at edge): all stages, TAP_VALID, TAP_OUT, FILL, FULL, SHIFTED -> 0. Highest priority.
- Priority at each edge: reset > CLR > shift > hold.
- Shift event: EN=1 and D_valid=1 and CLR=0. Stage0 <= D, stage k <= stage k-1, TAP_VALID <= {TAP_VALID[DEPTH-2:0],1}. The old stage DEPTH-1 is discarded.
- EN=1 with D_valid=0, or EN=0: stages, TAP_VALID, FILL hold.
- FILL increments by 1 per shift up to DEPTH, then holds (saturating, no wrap). FULL is set in the same edge that FILL reaches DEPTH.
- TAP_VALID is always a thermometer code of FILL (low FILL bits set).
- CLR=1 at edge (any EN): stages, TAP_VALID, FILL, FULL -> 0. TAP_OUT -> 0. SHIFTED -> 0. A D_valid in the same cycle is dropped.
- TAP_OUT latency 1: at edge n it loads the pre-edge value of stage[TAP_SEL]. It is updated every cycle regardless of EN. TAP_SEL >= DEPTH loads 0.
- SHIFTED <= shift event (registered), so it aligns with updated TAPS.
- Mid-operation reset or CLR behaves identically from the next cycle: empty line, FILL=0. The first sample afterwards lands in stage 0 with TAP_VALID=1.
- No combinational path from D to any output. Q and Q_valid are register aliases.
- All width arithmetic is unsigned. FILL needs SEL_W+1 bits to represent DEPTH exactly.

Test Plan:
- Reset: WIDTH=8, DEPTH=4, RST_n=0 for 2 cycles with D=0xFF, D_valid=1, EN=1 -> TAPS=0, TAP_VALID=0000, FILL=0, FULL=0, SHIFTED=0 every cycle.
- Fill and saturate: push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> FILL goes 1,2,3,4,4. FULL=1 from the 4th push. Final TAPS stage0..3 = 0x55,0x44,0x33,0x22. Q=0x22, Q_valid=1.
- Gaps and enable: push 0xA1, then D_valid=0 for 3 cycles, then EN=0 with D_valid=1 D=0xB2 -> TAPS unchanged (stage0=0xA1, FILL=1). SHIFTED pulses exactly once.
- Tap readout: line full 0x55,0x44,0x33,0x22; TAP_SEL=2 -> TAP_OUT=0x33 one cycle later. TAP_SEL changed to 0 -> TAP_OUT=0x55 next cycle. DEPTH=6 build with TAP_SEL=7 -> TAP_OUT=0.
- Flush vs push: full line, CLR=1 with D_valid=1 D=0x99 -> next cycle TAPS=0, FILL=0, FULL=0, SHIFTED=0. Following push 0x99 -> stage0=0x99, TAP_VALID=0001.
- Reset mid-fill: after 2 pushes assert RST_n=0 one cycle with CLR=1 and D_valid=1 -> all outputs 0. Refill of 4 samples reaches FULL on the 4th push.
